stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- Parametrised 1-to-NUM_CH demultiplexer for valid/ready streams. It generalises the combinational 1-to-4 demux to arbitrary data width and channel count.
- Adds a registered output slot per channel, back-pressure, a broadcast mode and invalid-select accounting.
- Sits between a single producer and NUM_CH independent consumers.

Parameters:
- DATA_W, 8, payload width in bits (>=1)
- NUM_CH, 4, number of output channels (2..16, need not be a power of two)
- SEL_W, $clog2(NUM_CH), select width; derived, not overridden
- CNT_W, 16, width of the drop counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a beat
- in_ready  output  1  block accepts the beat this cycle
- in_data  input  DATA_W  payload
- in_sel  input  SEL_W  destination channel (unicast)
- in_bcast  input  1  1 = deliver the beat to every channel, in_sel ignored
- out_valid  output  NUM_CH  per-channel beat present
- out_ready  input  NUM_CH  per-channel consumer accepts
- out_data  output  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- err_sel  output  1  one-cycle pulse: a beat with out-of-range in_sel was dropped
- drop_cnt  output  CNT_W  saturating count of dropped beats

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, err_sel=0, drop_cnt=0.
  - in_ready is forced 0 while rst_n is low.
- Channel slot: one-entry register per channel, holding a valid bit and a data word.
  - free_k = !out_valid[k] || out_ready[k], i.e. empty or draining this cycle.
- in_ready is combinational from slot state and out_ready. It must not depend on in_valid.
  - Unicast, in_sel < NUM_CH: in_ready = free_[in_sel].
  - Unicast, in_sel >= NUM_CH: in_ready = 1, so the beat is sunk.
  - Broadcast: in_ready = AND of free_k over all k.
- Transfer: fires on in_valid && in_ready at the clock edge.
  - Unicast valid: slot[in_sel] loads in_data, out_valid[in_sel]=1 next cycle.
  - Broadcast: every slot loads in_data, all out_valid=1 next cycle.
  - Invalid select: no slot loads, err_sel=1 for exactly the next cycle, drop_cnt increments.
  - drop_cnt saturates at 2^CNT_W-1 and never wraps.
- Latency: 1 cycle from accepted input to out_valid. Throughput is 1 beat/cycle per channel with a ready consumer.
- Output hold: while out_valid[k] && !out_ready[k], out_data[k] and out_valid[k] stay stable.
- Drain: out_valid[k] && out_ready[k] with no new load gives out_valid[k]=0 next cycle. out_data[k] keeps its last value; it is not cleared.
- Simultaneous drain and load on the same channel: the slot takes the new beat and out_valid stays 1. This is a back-to-back beat with no bubble.
- Other channels are unaffected by a unicast transfer. Drains on non-target channels proceed independently.
- in_bcast with in_sel out of range: broadcast takes precedence, no error.
- Reset mid-operation: all slots are emptied immediately. In-flight beats are lost, and drop_cnt is not incremented for them.
- No combinational path from in_valid/in_data to any output except through registers. The only combinational path to in_ready is from in_sel, in_bcast and out_ready.

Decomposition:
- Package stream_demux_pkg:
  - localparam defaults DATA_W_DEF=8, NUM_CH_DEF=4, CNT_W_DEF=16.
  - function sel_in_range(sel, num_ch).
- Sub-module demux_slot (parametrised by DATA_W):
  - Ports: clk, rst_n, load, load_data, out_ready, out_valid, out_data, free.
  - Instantiated NUM_CH times in a generate loop.
- The top holds the select decode, in_ready reduction and drop counter.

Test Plan:
- Reset, then unicast in_data=8'hA5, in_sel=2, all out_ready=1 -> next cycle out_valid=4'b0100, channel-2 data=A5; the following cycle out_valid=0.
- Back-pressure: out_ready[1]=0, send 8'h11 then 8'h22 to sel=1 -> first accepted; in_ready=0 on the second. Then raise out_ready[1]: 11 drains and 22 is accepted the same cycle, out_valid[1] stays 1, next out_data=22.
- Broadcast 8'h3C with out_ready=4'b1110 and slot 0 full -> in_ready=0. After out_ready[0]=1, the beat is accepted and all four channels show 3C with out_valid=4'b1111.
- NUM_CH=5, in_sel=6, in_valid=1 -> in_ready=1, no out_valid change, err_sel pulses 1 cycle, drop_cnt=1. Repeat with CNT_W=2 four times -> drop_cnt saturates at 3.
- Streaming: 100 random beats with random sel and random out_ready -> per-channel scoreboard sees order preserved, no loss or duplication, 1 beat/cycle when ready.
- Assert rst_n low while three slots are full -> out_valid=0 asynchronously and in_ready=0. After release, the first accepted beat appears with 1-cycle latency.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared defaults and helpers for the stream demultiplexer.
//   DATA_W_DEF / NUM_CH_DEF / CNT_W_DEF : default parameter values
//   sel_in_range()                      : true when a select addresses a real channel
package stream_demux_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 16;

  function automatic logic sel_in_range(input int sel, input int num_ch);
    return sel < num_ch;
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// stream_demux_if: producer-side and consumer-side valid/ready bundle.
//   in_*    : single input stream (valid, ready, data, select, broadcast)
//   out_*   : NUM_CH output streams; out_data[k] is channel k, same bit
//             layout as a flat NUM_CH*DATA_W vector ([k*DATA_W +: DATA_W])
//   master  : environment view (drives input stream and out_ready)
//   slave   : demux view
interface stream_demux_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic                           in_valid;
  logic                           in_ready;
  logic [DATA_W-1:0]              in_data;
  logic [SEL_W-1:0]               in_sel;
  logic                           in_bcast;
  logic [NUM_CH-1:0]              out_valid;
  logic [NUM_CH-1:0]              out_ready;
  logic [NUM_CH-1:0][DATA_W-1:0]  out_data;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_slot.sv
// demux_slot: one-entry output register for a single demux channel.
//   load/load_data : write a new beat (only asserted when free is high)
//   out_ready      : consumer accepts the held beat
//   out_valid/data : held beat; data is kept after a drain, not cleared
//   free           : slot empty or draining this cycle
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              free
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign free = !valid_q || out_ready;

  // A load while draining keeps valid high: back-to-back beats, no bubble.
  always_comb begin
    valid_d = load || (valid_q && !out_ready);
    data_d  = load ? load_data : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/stream_demux.sv
// stream_demux: 1-to-NUM_CH valid/ready demultiplexer with a registered slot
// per channel, broadcast, and accounting of beats with an out-of-range select.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream_demux_if slave (input stream + NUM_CH output streams)
//   err_sel    : one-cycle pulse after a bad-select beat was dropped
//   drop_cnt   : saturating count of dropped beats
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_demux_if.slave    bus,
  output logic             err_sel,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int SEL_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]             free;
  logic [NUM_CH-1:0]             load;
  logic [NUM_CH-1:0]             vld;
  logic [NUM_CH-1:0][DATA_W-1:0] dat;
  logic                          sel_ok, in_rdy, fire, drop_fire;
  logic                          err_q, err_d;
  logic [CNT_W-1:0]              drop_q, drop_d;

  assign sel_ok = sel_in_range(32'(bus.in_sel), NUM_CH);

  // Ready never looks at in_valid; a bad select is always sunk.
  always_comb begin
    in_rdy = 1'b1;
    if (!rst_n)            in_rdy = 1'b0;
    else if (bus.in_bcast) in_rdy = &free;
    else if (sel_ok)       in_rdy = free[bus.in_sel];
  end

  assign bus.in_ready = in_rdy;
  assign fire         = bus.in_valid && in_rdy;
  // Broadcast wins over an out-of-range select.
  assign drop_fire    = fire && !bus.in_bcast && !sel_ok;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign load[k] = fire && (bus.in_bcast || (sel_ok && (bus.in_sel == SEL_W'(k))));

    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (bus.in_data),
      .out_ready (bus.out_ready[k]),
      .out_valid (vld[k]),
      .out_data  (dat[k]),
      .free      (free[k])
    );
  end

  assign bus.out_valid = vld;
  assign bus.out_data  = dat;

  always_comb begin
    err_d  = drop_fire;
    drop_d = drop_q;
    if (drop_fire && (drop_q != {CNT_W{1'b1}})) drop_d = drop_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      err_q  <= err_d;
      drop_q <= drop_d;
    end
  end

  assign err_sel  = err_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: scoreboard bench. Instance A (4 ch) carries directed and
// random traffic checked against per-channel expected-beat queues; instance B
// (5 ch, 2-bit counter) covers non-power-of-two selects and counter saturation.
module tb_stream_demux;
  import stream_demux_pkg::*;

  localparam int DW = 8;
  localparam int NA = 4;
  localparam int NB = 5;
  localparam int CB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_demux_if #(.DATA_W(DW), .NUM_CH(NA)) ia ();
  stream_demux_if #(.DATA_W(DW), .NUM_CH(NB)) ib ();

  logic          err_a, err_b;
  logic [15:0]   drop_a;
  logic [CB-1:0] drop_b;

  stream_demux #(.DATA_W(DW), .NUM_CH(NA), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ia), .err_sel(err_a), .drop_cnt(drop_a)
  );
  stream_demux #(.DATA_W(DW), .NUM_CH(NB), .CNT_W(CB)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ib), .err_sel(err_b), .drop_cnt(drop_b)
  );

  int ncmp = 0;
  int nbad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model for A: each queue holds the beats a channel still owes,
  // oldest first. pend[k] counts beats pushed this cycle, not yet visible.
  logic [DW-1:0] q[NA][$];
  int            pend[NA];

  // Drive one cycle on A, predict acceptance from the model, record beats.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [1:0] s,
                     input logic bc, input logic [NA-1:0] rdy, output logic acc);
    logic er;
    @(posedge clk); #1;
    ia.in_valid = v; ia.in_data = d; ia.in_sel = s; ia.in_bcast = bc; ia.out_ready = rdy;
    for (int k = 0; k < NA; k++) pend[k] = 0;
    er = 1'b1;
    if (bc) begin
      for (int k = 0; k < NA; k++) if (q[k].size() != 0 && !rdy[k]) er = 1'b0;
    end else begin
      er = (q[s].size() == 0) || rdy[s];
    end
    if (!rst_n) er = 1'b0;
    acc = v && er;
    if (acc) begin
      for (int k = 0; k < NA; k++)
        if (bc || (k == int'(s))) begin q[k].push_back(d); pend[k] = 1; end
    end
    @(negedge clk);
    chk("a_in_ready", 64'(ia.in_ready), 64'(er));
  endtask

  // Monitor for A: every channel's valid against the model, data popped on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NA; k++) begin
        chk($sformatf("a_out_valid_ch%0d", k), 64'(ia.out_valid[k]), 64'(q[k].size() > pend[k]));
        if (ia.out_valid[k] && ia.out_ready[k] && (q[k].size() > pend[k])) begin
          chk($sformatf("a_out_data_ch%0d", k), 64'(ia.out_data[k]), 64'(q[k][0]));
          void'(q[k].pop_front());
        end
      end
      chk("a_err_sel", 64'(err_a), 64'(0));
      chk("a_drop_cnt", 64'(drop_a), 64'(0));
    end
  end

  task automatic bcyc(input logic v, input logic [DW-1:0] d, input logic [2:0] s, input logic bc);
    @(posedge clk); #1;
    ib.in_valid = v; ib.in_data = d; ib.in_sel = s; ib.in_bcast = bc; ib.out_ready = '1;
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    int   nacc, guard, expd;
    for (int k = 0; k < NA; k++) pend[k] = 0;
    ia.in_valid = 1'b1; ia.in_data = '0; ia.in_sel = '0; ia.in_bcast = 1'b0; ia.out_ready = '1;
    ib.in_valid = 1'b0; ib.in_data = '0; ib.in_sel = '0; ib.in_bcast = 1'b0; ib.out_ready = '1;

    // Reset state; in_ready is held low even with an empty target slot.
    #1;
    chk("rst_out_valid", 64'(ia.out_valid), 64'(0));
    chk("rst_out_data", 64'(ia.out_data), 64'(0));
    chk("rst_in_ready", 64'(ia.in_ready), 64'(0));
    chk("rst_err_sel", 64'(err_a), 64'(0));
    chk("rst_drop_cnt", 64'(drop_a), 64'(0));
    ia.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Unicast to channel 2, one-cycle latency then drained.
    cyc(1'b1, 8'hA5, 2'd2, 1'b0, 4'hF, acc);
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, acc);
    chk("uni_out_valid", 64'(ia.out_valid), 64'(4'b0100));
    chk("uni_out_data2", 64'(ia.out_data[2]), 64'(8'hA5));
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, acc);
    chk("uni_drained", 64'(ia.out_valid), 64'(0));
    chk("uni_data_kept", 64'(ia.out_data[2]), 64'(8'hA5));

    // Back-pressure on channel 1, then drain and reload in the same cycle.
    cyc(1'b1, 8'h11, 2'd1, 1'b0, 4'b1101, acc);
    cyc(1'b1, 8'h22, 2'd1, 1'b0, 4'b1101, acc);
    chk("bp_stall", 64'(ia.in_ready), 64'(0));
    chk("bp_hold_data", 64'(ia.out_data[1]), 64'(8'h11));
    cyc(1'b1, 8'h22, 2'd1, 1'b0, 4'hF, acc);
    chk("bp_accept_on_drain", 64'(ia.in_ready), 64'(1));
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, acc);
    chk("bp_no_bubble", 64'(ia.out_valid[1]), 64'(1));
    chk("bp_new_data", 64'(ia.out_data[1]), 64'(8'h22));

    // Broadcast blocked by a full, stalled slot 0.
    cyc(1'b1, 8'h77, 2'd0, 1'b0, 4'b1110, acc);
    cyc(1'b1, 8'h3C, 2'd3, 1'b1, 4'b1110, acc);
    chk("bc_blocked", 64'(ia.in_ready), 64'(0));
    cyc(1'b1, 8'h3C, 2'd3, 1'b1, 4'hF, acc);
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'h0, acc);
    chk("bc_all_valid", 64'(ia.out_valid), 64'(4'hF));
    for (int k = 0; k < NA; k++) chk($sformatf("bc_data_ch%0d", k), 64'(ia.out_data[k]), 64'(8'h3C));
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, acc);

    // Full-rate burst to one channel.
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h60 + i), 2'd3, 1'b0, 4'hF, acc);
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, acc);

    // Random streaming: 100 accepted beats, random select/broadcast/ready.
    nacc = 0; guard = 0;
    while (nacc < 100 && guard < 2000) begin
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 7) == 0), 4'($urandom), acc);
      if (acc) nacc++;
      guard++;
    end
    repeat (3) cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, acc);
    for (int k = 0; k < NA; k++) chk($sformatf("rand_drained_ch%0d", k), 64'(q[k].size()), 64'(0));

    // Instance B: out-of-range selects are sunk, pulse err_sel, counter saturates.
    for (int i = 0; i < 4; i++) begin
      expd = (i + 1 > 3) ? 3 : i + 1;
      bcyc(1'b1, 8'(8'hE0 + i), 3'd6, 1'b0);
      chk("b_bad_sel_ready", 64'(ib.in_ready), 64'(1));
      bcyc(1'b0, 8'h00, 3'd0, 1'b0);
      chk("b_err_pulse", 64'(err_b), 64'(1));
      chk("b_drop_cnt", 64'(drop_b), 64'(expd));
      chk("b_no_valid", 64'(ib.out_valid), 64'(0));
      bcyc(1'b0, 8'h00, 3'd0, 1'b0);
      chk("b_err_clear", 64'(err_b), 64'(0));
    end
    bcyc(1'b1, 8'h5C, 3'd7, 1'b1);
    chk("b_bc_ready", 64'(ib.in_ready), 64'(1));
    bcyc(1'b0, 8'h00, 3'd0, 1'b0);
    chk("b_bc_valid", 64'(ib.out_valid), 64'(5'h1F));
    chk("b_bc_data4", 64'(ib.out_data[4]), 64'(8'h5C));
    chk("b_bc_no_err", 64'(err_b), 64'(0));
    chk("b_bc_drop_hold", 64'(drop_b), 64'(3));
    bcyc(1'b1, 8'h44, 3'd4, 1'b0);
    bcyc(1'b0, 8'h00, 3'd0, 1'b0);
    chk("b_top_ch_valid", 64'(ib.out_valid), 64'(5'b10000));
    chk("b_top_ch_data", 64'(ib.out_data[4]), 64'(8'h44));

    // Reset with three slots full: outputs clear asynchronously.
    cyc(1'b1, 8'hC0, 2'd0, 1'b0, 4'h0, acc);
    cyc(1'b1, 8'hC1, 2'd1, 1'b0, 4'h0, acc);
    cyc(1'b1, 8'hC2, 2'd2, 1'b0, 4'h0, acc);
    cyc(1'b1, 8'hC3, 2'd0, 1'b0, 4'h0, acc);
    chk("pre_rst_full", 64'(ia.out_valid), 64'(4'b0111));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(ia.out_valid), 64'(0));
    chk("async_rst_ready", 64'(ia.in_ready), 64'(0));
    for (int k = 0; k < NA; k++) begin q[k].delete(); pend[k] = 0; end
    ia.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 8'h5A, 2'd3, 1'b0, 4'hF, acc);
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, acc);
    chk("post_rst_valid", 64'(ia.out_valid), 64'(4'b1000));
    chk("post_rst_data", 64'(ia.out_data[3]), 64'(8'h5A));
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
